// File: rtl/fix_ari_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fix_ari_pkg
// Brief    : Shared defaults and saturation bounds for the fix_ari arithmetic family.
// Revision : 1.0
// ============================================================================
package fix_ari_pkg;

    localparam int DATA_DEF = 15;
    localparam int CNTW_DEF = 16;

    function automatic longint fix_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    function automatic longint fix_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fix_ari_sub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fix_ari_sub_pipe_if
// Brief    : Operand-in / result-out valid-ready streams of the subtractor pipe.
// Revision : 1.0
// ============================================================================
interface fix_ari_sub_pipe_if
    import fix_ari_pkg::*;
#(
    parameter int DATA = DATA_DEF
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic signed [DATA-1:0] data_in1;
    logic signed [DATA-1:0] data_in2;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [DATA-1:0] data_out;
    logic                   sat_pos;
    logic                   sat_neg;

    modport master (
        output in_valid, data_in1, data_in2, out_ready,
        input  in_ready, out_valid, data_out, sat_pos, sat_neg
    );

    modport slave (
        input  in_valid, data_in1, data_in2, out_ready,
        output in_ready, out_valid, data_out, sat_pos, sat_neg
    );

endinterface
`default_nettype wire

// File: rtl/fix_ari_sat.sv
`default_nettype none
// ============================================================================
// Module   : fix_ari_sat
// Brief    : Clamps a DATA+1 bit signed value into DATA bits with overflow flags.
// Revision : 1.0
// ============================================================================
module fix_ari_sat
    import fix_ari_pkg::*;
#(
    parameter int DATA = DATA_DEF
) (
    input  logic signed [DATA:0]   value,
    output logic signed [DATA-1:0] result,
    output logic                   pos,
    output logic                   neg
);

    localparam logic signed [DATA-1:0] MAX_V = DATA'(fix_max(DATA));
    localparam logic signed [DATA-1:0] MIN_V = DATA'(fix_min(DATA));

    // The value fits in DATA bits exactly when its top two bits agree.
    always_comb begin
        pos    = ~value[DATA] &  value[DATA-1];
        neg    =  value[DATA] & ~value[DATA-1];
        result = $signed(value[DATA-1:0]);
        if (pos) begin
            result = MAX_V;
        end else if (neg) begin
            result = MIN_V;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fix_ari_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fix_ari_sub_pipe
// Brief    : Two-stage valid/ready saturating subtractor with saturation counter.
// Revision : 1.0
// ============================================================================
module fix_ari_sub_pipe
    import fix_ari_pkg::*;
#(
    parameter int DATA = DATA_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_cnt,
    output logic [CNTW-1:0]   sat_cnt,
    fix_ari_sub_pipe_if.slave bus
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic signed [DATA:0]   s1_diff;
    logic                   s1_valid;
    logic                   s2_valid;
    logic signed [DATA-1:0] s2_data;
    logic                   s2_pos;
    logic                   s2_neg;
    logic                   s2_free;
    logic                   in_fire;
    logic                   out_fire;
    logic signed [DATA-1:0] sat_res;
    logic                   sat_p;
    logic                   sat_n;

    // Stage 2 can take new data when empty or draining; stage 1 follows it.
    assign s2_free       = ~s2_valid | bus.out_ready;
    assign bus.in_ready  = ~s1_valid | s2_free;
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = s2_valid & bus.out_ready;

    assign bus.out_valid = s2_valid;
    assign bus.data_out  = s2_data;
    assign bus.sat_pos   = s2_pos;
    assign bus.sat_neg   = s2_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_diff  <= $signed({bus.data_in1[DATA-1], bus.data_in1})
                      - $signed({bus.data_in2[DATA-1], bus.data_in2});
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    fix_ari_sat #(
        .DATA   (DATA)
    ) u_sat (
        .value  (s1_diff),
        .result (sat_res),
        .pos    (sat_p),
        .neg    (sat_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_pos   <= 1'b0;
            s2_neg   <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= sat_res;
                s2_pos  <= sat_p;
                s2_neg  <= sat_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (clr_cnt) begin
            sat_cnt <= '0;
        end else if (out_fire && (s2_pos || s2_neg) && (sat_cnt != CNT_MAX)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fix_ari_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fix_ari_sub_pipe
// Brief    : Self-checking bench for fix_ari_sub_pipe against a saturating-subtract model.
// Revision : 1.0
// ============================================================================
module tb_fix_ari_sub_pipe;

    localparam int DATA = 15;
    localparam int CNTW = 16;
    localparam int MAXI = 16383;
    localparam int MINI = -16384;

    typedef struct {
        int val;
        bit pos;
        bit neg;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr_cnt = 1'b0;
    logic [CNTW-1:0] sat_cnt;
    int              total = 0;
    int              bad = 0;

    fix_ari_sub_pipe_if #(.DATA(DATA)) bus ();

    fix_ari_sub_pipe #(
        .DATA    (DATA),
        .CNTW    (CNTW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_cnt (clr_cnt),
        .sat_cnt (sat_cnt),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t ref_sub(input int a, input int b);
        exp_t e;
        int   d;
        d = a - b;
        e.pos = (d > MAXI);
        e.neg = (d < MINI);
        e.val = e.pos ? MAXI : (e.neg ? MINI : d);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one pair with out_ready high; sample the result two edges later, then let it drain.
    task automatic run_pair(input int a, input int b, output logic ov,
                            output logic signed [DATA-1:0] d, output logic p, output logic n);
        bus.data_in1  = DATA'(a);
        bus.data_in2  = DATA'(b);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        ov = bus.out_valid;
        d  = bus.data_out;
        p  = bus.sat_pos;
        n  = bus.sat_neg;
        tick();
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in1  = '0;
        bus.data_in2  = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.data_out !== '0) begin bad++; $display("FAIL reset_data_out got=%0d want=0", $signed(bus.data_out)); end
        total++; if (bus.sat_pos !== 1'b0 || bus.sat_neg !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", bus.sat_pos, bus.sat_neg); end
        total++; if (sat_cnt !== '0) begin bad++; $display("FAIL reset_sat_cnt got=%0d want=0", sat_cnt); end
        rst_n = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        bus.data_in1  = DATA'(100);
        bus.data_in2  = DATA'(30);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", bus.out_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", bus.out_valid); end
        total++; if ($signed(bus.data_out) !== 15'sd70) begin bad++; $display("FAIL basic_data got=%0d want=70", $signed(bus.data_out)); end
        total++; if (bus.sat_pos !== 1'b0 || bus.sat_neg !== 1'b0) begin bad++; $display("FAIL basic_flags got=%b%b want=00", bus.sat_pos, bus.sat_neg); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_saturation();
        int a_tab[4] = '{MINI, MAXI, MINI, 0};
        int b_tab[4] = '{1, -1, MINI, MINI};
        int cnt_exp = 0;
        logic ov, p, n;
        logic signed [DATA-1:0] d;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e = ref_sub(a_tab[i], b_tab[i]);
            run_pair(a_tab[i], b_tab[i], ov, d, p, n);
            if (e.pos || e.neg) cnt_exp++;
            total++; if (ov !== 1'b1) begin bad++; $display("FAIL sat_valid[%0d] got=%b want=1", i, ov); end
            total++; if (d !== DATA'(e.val)) begin bad++; $display("FAIL sat_data[%0d] got=%0d want=%0d", i, $signed(d), e.val); end
            total++; if (p !== e.pos || n !== e.neg) begin bad++; $display("FAIL sat_flags[%0d] got=%b%b want=%b%b", i, p, n, e.pos, e.neg); end
            total++; if (sat_cnt !== CNTW'(cnt_exp)) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", i, sat_cnt, cnt_exp); end
        end
    endtask

    task automatic test_random_stream();
        exp_t q[$];
        exp_t e;
        int   sent = 0, got = 0, cyc = 0, inflight;
        int   a_cur = 0, b_cur = 0;
        bit   stalled = 0, accepted;
        logic want_ready;
        logic signed [DATA-1:0] held_d = '0;
        logic held_p = 1'b0, held_n = 1'b0;
        bus.in_valid = 1'b0;
        while (got < 10 && cyc < 500) begin
            if (!bus.in_valid && sent < 10 && $urandom_range(0, 3) != 0) begin
                a_cur = int'($urandom_range(0, 32767)) - 16384;
                b_cur = int'($urandom_range(0, 32767)) - 16384;
                bus.data_in1 = DATA'(a_cur);
                bus.data_in2 = DATA'(b_cur);
                bus.in_valid = 1'b1;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            inflight   = sent - got;
            want_ready = (inflight < 2) || bus.out_ready;
            total++; if (bus.in_ready !== want_ready) begin bad++; $display("FAIL stream_in_ready cyc=%0d got=%b want=%b inflight=%0d", cyc, bus.in_ready, want_ready, inflight); end
            if (stalled) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.data_out !== held_d || bus.sat_pos !== held_p || bus.sat_neg !== held_n) begin
                    bad++;
                    $display("FAIL stream_stall_hold cyc=%0d got=%b/%0d/%b%b want=1/%0d/%b%b", cyc, bus.out_valid,
                             $signed(bus.data_out), bus.sat_pos, bus.sat_neg, $signed(held_d), held_p, held_n);
                end
            end
            stalled = 0;
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stream_spurious cyc=%0d got=%0d want=none", cyc, $signed(bus.data_out));
                end else if (bus.out_ready) begin
                    e = q.pop_front();
                    got++;
                    total++;
                    if (bus.data_out !== DATA'(e.val) || bus.sat_pos !== e.pos || bus.sat_neg !== e.neg) begin
                        bad++;
                        $display("FAIL stream_result[%0d] got=%0d/%b%b want=%0d/%b%b", got - 1, $signed(bus.data_out),
                                 bus.sat_pos, bus.sat_neg, e.val, e.pos, e.neg);
                    end
                end else begin
                    stalled = 1;
                    held_d  = bus.data_out;
                    held_p  = bus.sat_pos;
                    held_n  = bus.sat_neg;
                end
            end
            accepted = bus.in_valid && bus.in_ready;
            if (accepted) begin
                q.push_back(ref_sub(a_cur, b_cur));
                sent++;
            end
            tick();
            if (accepted) bus.in_valid = 1'b0;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total++; if (got != 10) begin bad++; $display("FAIL stream_timeout got=%0d want=10", got); end
        tick();
    endtask

    task automatic test_counter();
        logic ov, p, n;
        logic signed [DATA-1:0] d;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        total++; if (sat_cnt !== '0) begin bad++; $display("FAIL cnt_clear got=%0d want=0", sat_cnt); end
        bus.data_in1  = DATA'(MINI);
        bus.data_in2  = DATA'(1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        repeat (65540) tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        total++; if (sat_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_stick got=%0d want=65535", sat_cnt); end
        // Saturating result reaches the output in the same cycle clr_cnt is high.
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.sat_neg !== 1'b1) begin bad++; $display("FAIL cnt_pre_clr got=%b%b want=11", bus.out_valid, bus.sat_neg); end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        total++; if (sat_cnt !== '0) begin bad++; $display("FAIL cnt_clr_priority got=%0d want=0", sat_cnt); end
        run_pair(MAXI, -5, ov, d, p, n);
        total++; if (sat_cnt !== 16'd1) begin bad++; $display("FAIL cnt_after_clr got=%0d want=1", sat_cnt); end
    endtask

    task automatic test_reset_midflight();
        logic ov, p, n;
        logic signed [DATA-1:0] d;
        bus.out_ready = 1'b0;
        bus.data_in1  = DATA'(MAXI);
        bus.data_in2  = DATA'(-9);
        bus.in_valid  = 1'b1;
        tick();
        bus.data_in1 = DATA'(3);
        bus.data_in2 = DATA'(4);
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%b%b want=10", bus.out_valid, bus.in_ready); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.data_out !== '0 || bus.sat_pos !== 1'b0 || sat_cnt !== '0) begin bad++; $display("FAIL mid_clear got=%0d/%b/%0d want=0/0/0", $signed(bus.data_out), bus.sat_pos, sat_cnt); end
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d] got=%b want=0", i, bus.out_valid); end
        end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", bus.in_ready); end
        run_pair(5, 7, ov, d, p, n);
        total++; if (ov !== 1'b1 || d !== -15'sd2 || p !== 1'b0 || n !== 1'b0) begin bad++; $display("FAIL mid_new_pair got=%b/%0d/%b%b want=1/-2/00", ov, $signed(d), p, n); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_random_stream();
        test_counter();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
